// File: rtl/alu_result_reader.sv
`default_nettype none
// ============================================================================
// Module   : alu_result_reader
// Purpose  : Drains the 16 x 4-bit ALU result memory over a valid/ready
//            stream. A start pulse sweeps a contiguous address window
//            (wrapping modulo the memory depth). Each word is presented
//            together with the address it came from. A running checksum and
//            a count of zero-valued words are kept for readback.
// Ports    :
//   clk, rst      rising-edge clock, asynchronous active-high reset
//   start         sweep request, sampled only while idle
//   base_addr     first address of the sweep
//   count         words to read (0..DEPTH, larger values clamp to DEPTH)
//   mem_addr      registered read address to the result memory
//   mem_rdata     combinational read data for mem_addr
//   out_data      streamed word
//   out_addr      address out_data was read from
//   out_valid     out_data/out_addr/out_last are valid
//   out_ready     downstream accepts the current word
//   out_last      current word is the final word of the sweep
//   busy          sweep in progress
//   done          one-cycle pulse after the sweep completes
//   checksum      mod-256 sum of the accepted words of the last sweep
//   zero_count    number of accepted words equal to zero
// Revision : 1.0 - initial release
// ============================================================================
module alu_result_reader #(
    parameter int DATA_W = 4,
    parameter int ADDR_W = 4,
    parameter int CNT_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  count,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy,
    output logic              done,
    output logic [7:0]        checksum,
    output logic [CNT_W-1:0]  zero_count
);

    localparam int               DEPTH   = 1 << ADDR_W;
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(DEPTH);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_OUT   = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]       state;
    logic [1:0]       next_state;
    logic [CNT_W-1:0] remaining;
    logic [CNT_W-1:0] count_clamped;
    logic             handshake;

    assign count_clamped = (count > MAX_CNT) ? MAX_CNT : count;
    assign handshake     = out_valid && out_ready;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    // An empty sweep still reports completion through DONE.
                    next_state = (count_clamped != '0) ? S_FETCH : S_DONE;
                end
            end
            S_FETCH: next_state = S_OUT;
            S_OUT: begin
                if (handshake) begin
                    next_state = out_last ? S_DONE : S_FETCH;
                end
            end
            S_DONE:  next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // State-decoded outputs
    // ------------------------------------------------------------------
    always_comb begin
        busy = (state != S_IDLE);
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_addr   <= '0;
            out_data   <= '0;
            out_addr   <= '0;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            done       <= 1'b0;
            checksum   <= '0;
            zero_count <= '0;
            remaining  <= '0;
        end else begin
            // done is registered, so it is seen the cycle after DONE.
            done <= (state == S_DONE);
            case (state)
                S_IDLE: begin
                    if (start) begin
                        checksum   <= '0;
                        zero_count <= '0;
                        if (count_clamped != '0) begin
                            remaining <= count_clamped;
                            mem_addr  <= base_addr;
                        end
                    end
                end
                S_FETCH: begin
                    // The word is captured here; later memory writes to this
                    // address do not disturb the word being offered.
                    out_data  <= mem_rdata;
                    out_addr  <= mem_addr;
                    out_valid <= 1'b1;
                    out_last  <= (remaining == CNT_W'(1));
                end
                S_OUT: begin
                    if (handshake) begin
                        checksum  <= checksum + 8'(out_data);
                        if (out_data == '0) begin
                            zero_count <= zero_count + CNT_W'(1);
                        end
                        remaining <= remaining - CNT_W'(1);
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        if (!out_last) begin
                            mem_addr <= mem_addr + ADDR_W'(1);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/alu_result_reader.md
Name: alu_result_reader

Overview:
- Drains the 16-entry x 4-bit ALU result memory over a valid/ready stream. It is the read-side counterpart of the ALU's write port.
- After a start pulse, it walks a contiguous address window (wrapping mod 16) and presents each stored result with its address.
- It keeps a running checksum and a zero-result count for readback and debug.

Parameters:
- DATA_W, 4, width of one memory word / result
- ADDR_W, 4, memory address width; depth = 2**ADDR_W = 16
- CNT_W, 5, width of the transfer count (0..16)

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request a sweep; sampled only in IDLE
- base_addr  input  ADDR_W  first address of the sweep
- count  input  CNT_W  number of words to read (0..16; >16 treated as 16)
- mem_addr  output  ADDR_W  read address to the result memory (registered)
- mem_rdata  input  DATA_W  memory read data, combinational from mem_addr
- out_data  output  DATA_W  streamed result word
- out_addr  output  ADDR_W  address that out_data was read from
- out_valid  output  1  out_data/out_addr/out_last are valid
- out_ready  input  1  downstream accepts the current word
- out_last  output  1  current word is the final word of the sweep
- busy  output  1  sweep in progress (state != IDLE)
- done  output  1  one-cycle pulse at sweep completion
- checksum  output  8  sum of all accepted words in this sweep (mod 256)
- zero_count  output  CNT_W  number of accepted words equal to 0

Behaviour:
- Reset (async, rst=1):
  - state=IDLE.
  - mem_addr, out_data, out_addr, out_valid, out_last, busy, done, checksum and zero_count all = 0.
  - Reset asserted mid-sweep aborts it immediately; no done pulse is produced.
- States: IDLE, FETCH, OUT, DONE.
- IDLE:
  - start=1 with count!=0: latch the clamped count into remaining, set mem_addr=base_addr, clear checksum and zero_count, go to FETCH.
  - start=1 with count==0: clear checksum and zero_count, go to DONE. No words are streamed.
- FETCH (1 cycle):
  - Register out_data<=mem_rdata and out_addr<=mem_addr.
  - out_valid<=1; out_last<=(remaining==1).
  - Go to OUT.
- OUT:
  - While out_valid=1 and out_ready=0, out_data, out_addr and out_last are held stable. out_valid is never withdrawn before acceptance.
  - On handshake (out_valid && out_ready):
    - checksum += out_data (8-bit, wraps mod 256).
    - zero_count += (out_data==0).
    - remaining -= 1; out_valid<=0.
  - After the handshake: if out_last, go to DONE. Otherwise mem_addr<=mem_addr+1 (wraps 15->0) and go to FETCH.
- DONE (1 cycle):
  - done=1, busy=0 from the next cycle; return to IDLE.
  - checksum and zero_count hold until the next accepted start.
- busy=1 in FETCH, OUT and DONE. start is ignored while busy.
- Throughput: one word per 2 cycles when out_ready is held high. The first out_valid appears 2 cycles after the start edge.
- Memory contents are sampled in the FETCH cycle. A write to the word's address after its FETCH is not reflected in that word.

Test Plan:
- Memory preloaded with mem[i]=i; start with base=0, count=16, out_ready=1 -> words 0..15 stream in order with out_addr=0..15; out_last only on word 15; checksum=120; zero_count=1; a single done pulse.
- Same preload; base=14, count=4 -> out_addr sequence 14,15,0,1; data 14,15,0,1; checksum=30; zero_count=1.
- out_ready held low for 5 cycles on the 2nd word of a 3-word sweep -> out_data and out_addr stay stable and out_valid stays high; the sweep completes after release; checksum is correct.
- count=0 with start -> no out_valid at any point; done pulses 2 cycles after start; checksum=0.
- rst asserted while in OUT of word 3 of 8 -> all outputs are 0 immediately (async); no done pulse. A new start then runs a full sweep cleanly.
- start pulsed again while busy -> ignored; the sweep count and addresses are unchanged. All 16 words = 15 -> checksum=240.
